// File: rtl/m_div_unit.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU with a pipeline stall output.
// Build option DIV_FASTPATH_EN: divide-by-zero and signed overflow skip CALC (IDLE -> FIX).
//
//   state  | meaning
//   S_IDLE | waiting for a divide request
//   S_CALC | one restoring step per cycle, XLEN steps
//   S_FIX  | sign correction, result register, done pulse
module m_div_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_alu_mul_sel,
   input  logic [3:0]      i_m_con,
   input  logic            i_start,
   input  logic            i_kill,
   input  logic [XLEN-1:0] i_op_a,
   input  logic [XLEN-1:0] i_op_b,
   output logic [XLEN-1:0] o_result,
   output logic            o_done,
   output logic            o_busy,
   output logic            o_stall
);

   localparam int CW = $clog2(XLEN);
   localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

   state_t          r_state, w_state_nxt;
   logic [XLEN-1:0] r_rem, r_quo, r_div, r_result;
   logic [CW-1:0]   r_cnt;
   logic [1:0]      r_op_sel;
   logic            r_neg_q, r_neg_r, r_done, r_busy;

   logic            w_req, w_signed, w_fast;
   logic [XLEN-1:0] w_abs_a, w_abs_b, w_res;
   logic [XLEN:0]   w_rem_sh, w_trial;

   // 4'b10xx is the divide group; 11xx is not a divide
   assign w_req    = i_start & i_alu_mul_sel & i_m_con[3] & ~i_m_con[2];
   assign w_signed = ~i_m_con[0];
   assign w_abs_a  = (w_signed & i_op_a[XLEN-1]) ? -i_op_a : i_op_a;
   assign w_abs_b  = (w_signed & i_op_b[XLEN-1]) ? -i_op_b : i_op_b;

`ifdef DIV_FASTPATH_EN
   logic w_div_zero, w_ovf;
   assign w_div_zero = (i_op_b == '0);
   assign w_ovf      = w_signed & (i_op_a == {1'b1, {(XLEN-1){1'b0}}}) & (&i_op_b);
   assign w_fast     = w_div_zero | w_ovf;
`else
   assign w_fast     = 1'b0;
`endif

   // 33-bit trial: bit XLEN set means the shifted remainder is below the divisor
   assign w_rem_sh = {r_rem, r_quo[XLEN-1]};
   assign w_trial  = w_rem_sh - {1'b0, r_div};

   always_comb begin
      w_res = r_quo;
      case (r_op_sel)
         2'b00:   w_res = (r_neg_q && (r_div != '0)) ? -r_quo : r_quo;
         2'b01:   w_res = r_quo;
         2'b10:   w_res = r_neg_r ? -r_rem : r_rem;
         default: w_res = r_rem;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (i_kill) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:  if (w_req) w_state_nxt = w_fast ? S_FIX : S_CALC;
            S_CALC:  if (r_cnt == CNT_LAST) w_state_nxt = S_FIX;
            S_FIX:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rem    <= '0;
         r_quo    <= '0;
         r_div    <= '0;
         r_cnt    <= '0;
         r_op_sel <= '0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_result <= '0;
         r_done   <= 1'b0;
         r_busy   <= 1'b0;
      end else if (i_kill) begin
         r_done <= 1'b0;
         r_busy <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_req) begin
                  r_op_sel <= i_m_con[1:0];
                  r_neg_q  <= w_signed & (i_op_a[XLEN-1] ^ i_op_b[XLEN-1]);
                  r_neg_r  <= w_signed & i_op_a[XLEN-1];
                  r_div    <= w_abs_b;
                  r_rem    <= '0;
                  r_quo    <= w_abs_a;
                  r_cnt    <= '0;
                  r_busy   <= 1'b1;
`ifdef DIV_FASTPATH_EN
                  // preload what XLEN steps against a zero divisor would leave behind
                  if (w_div_zero) begin
                     r_rem <= w_abs_a;
                     r_quo <= '1;
                  end
`endif
               end
            end
            S_CALC: begin
               if (!w_trial[XLEN]) begin
                  r_rem <= w_trial[XLEN-1:0];
                  r_quo <= {r_quo[XLEN-2:0], 1'b1};
               end else begin
                  r_rem <= w_rem_sh[XLEN-1:0];
                  r_quo <= {r_quo[XLEN-2:0], 1'b0};
               end
               r_cnt <= r_cnt + 1'b1;
            end
            S_FIX: begin
               r_result <= w_res;
               r_done   <= 1'b1;
               r_busy   <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign o_result = r_result;
   assign o_done   = r_done;
   assign o_busy   = r_busy;
   assign o_stall  = r_busy | (w_req & (r_state == S_IDLE));

endmodule

// File: tb/tb_m_div_unit.sv
// Self-checking bench for m_div_unit: fixed vectors, corner sequences and a random
// sweep compared against a plain-arithmetic RV32M divide model.
module tb_m_div_unit;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic        sel = 1'b0, start = 1'b0, kill = 1'b0;
   logic [3:0]  mcon = '0;
   logic [31:0] a = '0, b = '0;
   logic [31:0] result;
   logic        done, busy, stall;

   int n_vec = 0, n_err = 0;

   typedef struct {
      logic [3:0]  mc;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl[12];

   m_div_unit #(.XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n), .i_alu_mul_sel(sel), .i_m_con(mcon),
      .i_start(start), .i_kill(kill), .i_op_a(a), .i_op_b(b),
      .o_result(result), .o_done(done), .o_busy(busy), .o_stall(stall)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Architectural RV32M results straight from the ISA rules
   function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
      longint sx, sy, r;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      if (y == 32'd0) return op[1] ? x : 32'hFFFF_FFFF;
      case (op)
         2'b00:   r = sx / sy;
         2'b01:   r = longint'({32'd0, x}) / longint'({32'd0, y});
         2'b10:   r = sx % sy;
         default: r = longint'({32'd0, x}) % longint'({32'd0, y});
      endcase
      return r[31:0];
   endfunction

   function automatic int exp_lat(input logic [3:0] mc, input logic [31:0] x, input logic [31:0] y);
`ifdef DIV_FASTPATH_EN
      if (y == 32'd0 || (!mc[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)) return 1;
`else
      if (mc[3] && x == 32'hFFFF_FFFF && y == 32'hFFFF_FFFF) return 33;
`endif
      return 33;
   endfunction

   // Present a request for one cycle; ops are scrambled afterwards to prove latching at accept
   task automatic issue(input logic [3:0] mc, input logic [31:0] oa, input logic [31:0] ob);
      @(negedge clk);
      start = 1'b1; sel = 1'b1; mcon = mc; a = oa; b = ob;
      #1 chk("stall_on_req", {31'd0, stall}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0; sel = 1'($urandom); mcon = 4'($urandom); a = $urandom; b = $urandom;
      chk("busy_after_accept", {31'd0, busy}, 32'd1);
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      while (done !== 1'b1 && lat < 60) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
   endtask

   task automatic run_op(input string name, input logic [3:0] mc, input logic [31:0] oa,
                         input logic [31:0] ob, input logic [31:0] exp);
      int lat;
      issue(mc, oa, ob);
      wait_done(lat);
      chk({name, "_lat"}, lat, exp_lat(mc, oa, ob));
      chk({name, "_res"}, result, exp);
      chk({name, "_busy_at_done"}, {31'd0, busy}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk({name, "_done_pulse"}, {31'd0, done}, 32'd0);
   endtask

   initial begin
      int lat;
      logic [1:0]  op;
      logic [31:0] ra, rb;

      tbl[0]  = '{4'b1000, 32'd100,        32'hFFFF_FFF9, 32'hFFFF_FFF2};
      tbl[1]  = '{4'b1010, 32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFFE};
      tbl[2]  = '{4'b1011, 32'hFFFF_FFFF,  32'd16,        32'h0000_000F};
      tbl[3]  = '{4'b1000, 32'd5,          32'd0,         32'hFFFF_FFFF};
      tbl[4]  = '{4'b1010, 32'd5,          32'd0,         32'd5};
      tbl[5]  = '{4'b1000, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
      tbl[6]  = '{4'b1010, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0};
      tbl[7]  = '{4'b1001, 32'd5,          32'd0,         32'hFFFF_FFFF};
      tbl[8]  = '{4'b1011, 32'd7,          32'd0,         32'd7};
      tbl[9]  = '{4'b1010, 32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFB};
      tbl[10] = '{4'b1000, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD};
      tbl[11] = '{4'b1001, 32'hFFFF_FFFE,  32'd3,         32'h5555_5554};

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_result", result, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_stall", {31'd0, stall}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // non-divide requests must neither stall nor start
      start = 1'b1; sel = 1'b0; mcon = 4'b0000;
      #1 chk("nondiv_stall", {31'd0, stall}, 32'd0);
      @(negedge clk);
      chk("nondiv_busy", {31'd0, busy}, 32'd0);
      sel = 1'b1; mcon = 4'b0011;
      #1 chk("mul_op_stall", {31'd0, stall}, 32'd0);
      @(negedge clk);
      chk("mul_op_busy", {31'd0, busy}, 32'd0);

      // request and kill together: kill wins
      mcon = 4'b1000; a = 32'd10; b = 32'd2; kill = 1'b1;
      #1 chk("reqkill_stall", {31'd0, stall}, 32'd1);
      @(negedge clk);
      start = 1'b0; kill = 1'b0;
      chk("reqkill_busy", {31'd0, busy}, 32'd0);
      wait_done(lat);
      chk("reqkill_no_done", lat, 32'd60);

      for (int i = 0; i < 12; i++)
         run_op($sformatf("vec%0d", i), tbl[i].mc, tbl[i].a, tbl[i].b, tbl[i].exp);

      // kill at CALC cycle 10: no done, result keeps the last value
      issue(4'b1001, 32'd1000, 32'd3);
      repeat (10) begin
         @(posedge clk);
         @(negedge clk);
      end
      kill = 1'b1;
      @(posedge clk);
      @(negedge clk);
      kill = 1'b0;
      chk("kill_busy", {31'd0, busy}, 32'd0);
      chk("kill_stall", {31'd0, stall}, 32'd0);
      wait_done(lat);
      chk("kill_no_done", lat, 32'd60);
      chk("kill_result_held", result, tbl[11].exp);
      @(negedge clk);
      run_op("after_kill", 4'b1001, 32'd9, 32'd2, 32'd4);

      // start pulsed while busy is ignored and not queued
      issue(4'b1001, 32'd100, 32'd7);
      lat = 0;
      while (done !== 1'b1 && lat < 60) begin
         if (lat == 5) begin
            start = 1'b1; sel = 1'b1; mcon = 4'b1000; a = 32'd1; b = 32'd1;
            #1 chk("busy_start_stall", {31'd0, stall}, 32'd1);
         end else begin
            start = 1'b0;
         end
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      start = 1'b0;
      chk("busy_start_lat", lat, 32'd33);
      chk("busy_start_res", result, 32'd14);
      @(negedge clk);
      chk("busy_start_not_queued", {31'd0, busy}, 32'd0);

      // random sweep against the model
      for (int i = 0; i < 40; i++) begin
         op = 2'($urandom_range(0, 3));
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 9))
            0: rb = 32'd0;
            1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            2: rb = 32'($urandom_range(1, 15));
            3: begin ra = 32'($urandom_range(0, 200)); rb = 32'($urandom_range(1, 300)); end
            default: ;
         endcase
         run_op($sformatf("rnd%0d", i), {2'b10, op}, ra, rb, model(op, ra, rb));
      end

      // async reset in the middle of a divide
      run_op("pre_reset", 4'b1001, 32'd77, 32'd1, 32'd77);
      issue(4'b1000, 32'd12345, 32'd67);
      repeat (15) begin
         @(posedge clk);
         @(negedge clk);
      end
      rst_n = 1'b0;
      #1;
      chk("midrst_result", result, 32'd0);
      chk("midrst_done", {31'd0, done}, 32'd0);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_stall", {31'd0, stall}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      wait_done(lat);
      chk("midrst_no_done", lat, 32'd60);
      run_op("post_reset", 4'b1000, 32'd12345, 32'd67, 32'd184);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
